// File: rtl/full_sub_pkg.sv
// Shared constants and the golden {borrow,diff} reference for the registered full subtractor.
package full_sub_pkg;

  localparam int FS_DEFAULT_WIDTH = 1;
  localparam int FS_MAX_WIDTH     = 32;

  // Result layout: diff in the low `width` bits, borrow in bit FS_MAX_WIDTH.
  function automatic logic [FS_MAX_WIDTH:0] fs_ref(
    input logic [FS_MAX_WIDTH-1:0] a,
    input logic [FS_MAX_WIDTH-1:0] b,
    input logic                    c,
    input int                      width
  );
    logic [FS_MAX_WIDTH-1:0] mask;
    logic [FS_MAX_WIDTH:0]   full;
    mask = {FS_MAX_WIDTH{1'b1}} >> (FS_MAX_WIDTH - width);
    full = {1'b0, a & mask} - {1'b0, b & mask} - {{FS_MAX_WIDTH{1'b0}}, c};
    return {full[FS_MAX_WIDTH], full[FS_MAX_WIDTH-1:0] & mask};
  endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// Combinational 1-bit full subtractor stage: d = a - b - bin, bout = borrow to the next bit.
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/full_subtractor_reg.sv
// Registered WIDTH-bit ripple-borrow subtractor computing a - b - c with one cycle of latency.
// Optional macro FULL_SUB_OVERFLOW_EN adds the registered signed-overflow output ovf.
module full_subtractor_reg
  import full_sub_pkg::*;
#(
  parameter int WIDTH = FS_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic             out_valid,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef FULL_SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH:0]   br;
  logic [WIDTH-1:0] d;

  assign br[0] = c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_subtractor_cell u_cell (
      .a   (a[i]),
      .b   (b[i]),
      .bin (br[i]),
      .d   (d[i]),
      .bout(br[i+1])
    );
  end

  // Operands are only sampled under in_valid, so X on idle inputs never reaches the outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      diff      <= '0;
      borrow    <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        diff   <= d;
        borrow <= br[WIDTH];
      end
    end
  end

`ifdef FULL_SUB_OVERFLOW_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= br[WIDTH] ^ br[WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_full_subtractor_reg.sv
// Bench for full_subtractor_reg: WIDTH=1 and WIDTH=8 instances, vector tables plus random traffic.
module tb_full_subtractor_reg;
  import full_sub_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       iv1 = 1'b0, a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
  logic       ov1, d1, bo1;
  logic       iv8 = 1'b0, c8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ov8, bo8;
  logic [7:0] d8;
`ifdef FULL_SUB_OVERFLOW_EN
  logic       of1, of8;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  full_subtractor_reg #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .a(a1), .b(b1), .c(c1),
    .out_valid(ov1), .diff(d1), .borrow(bo1)
`ifdef FULL_SUB_OVERFLOW_EN
    , .ovf(of1)
`endif
  );

  full_subtractor_reg #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .a(a8), .b(b8), .c(c8),
    .out_valid(ov8), .diff(d8), .borrow(bo8)
`ifdef FULL_SUB_OVERFLOW_EN
    , .ovf(of8)
`endif
  );

  typedef struct {
    logic a, b, c;
    logic d, bo;
  } vec1_t;

  typedef struct {
    logic [7:0] a, b;
    logic       c;
    logic [7:0] d;
    logic       bo, of;
  } vec8_t;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int r;
    r = int'(a) - int'(b) - int'(c);
    return {r < 0, 8'(r)};
  endfunction

  function automatic logic model8_ovf(input logic [7:0] a, input logic [7:0] b, input logic c);
    int s;
    s = int'($signed(a)) - int'($signed(b)) - int'(c);
    return (s > 127) || (s < -128);
  endfunction

  function automatic logic model1_ovf(input logic a, input logic b, input logic c);
    int s;
    s = -int'(a) + int'(b) - int'(c);
    return (s > 0) || (s < -1);
  endfunction

  vec1_t t1 [8];
  vec8_t t8 [6];

  initial begin
    logic [8:0]  m;
    logic [32:0] r;
    logic        exp_v;
    logic [7:0]  exp_d;
    logic        exp_b;
    logic        exp_o;

    t1[0] = '{0,0,0, 0,0}; t1[1] = '{0,0,1, 1,1};
    t1[2] = '{0,1,0, 1,1}; t1[3] = '{0,1,1, 0,1};
    t1[4] = '{1,0,0, 1,0}; t1[5] = '{1,0,1, 0,0};
    t1[6] = '{1,1,0, 0,0}; t1[7] = '{1,1,1, 1,1};

    t8[0] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    t8[1] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    t8[2] = '{8'h55, 8'h55, 1'b1, 8'hFF, 1'b1, 1'b0};
    t8[3] = '{8'h55, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0};
    t8[4] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
    t8[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};

    // Reset with valid operands present: reset must win.
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
    iv8 = 1'b1; a8 = 8'h12; b8 = 8'h03; c8 = 1'b0;
    tick(); tick();
    check("rst_ov1", 16'(ov1), 16'h0);
    check("rst_d1",  16'(d1),  16'h0);
    check("rst_bo1", 16'(bo1), 16'h0);
    check("rst_ov8", 16'(ov8), 16'h0);
    check("rst_d8",  16'(d8),  16'h0);
    check("rst_bo8", 16'(bo8), 16'h0);
    rst_n = 1'b1;

    // 1-bit truth table, one vector per cycle.
    for (int i = 0; i < 8; i++) begin
      iv1 = 1'b1; a1 = t1[i].a; b1 = t1[i].b; c1 = t1[i].c;
      tick();
      check($sformatf("w1_d[%0d]", i),  16'(d1),  16'(t1[i].d));
      check($sformatf("w1_bo[%0d]", i), 16'(bo1), 16'(t1[i].bo));
      check($sformatf("w1_ov[%0d]", i), 16'(ov1), 16'h1);
`ifdef FULL_SUB_OVERFLOW_EN
      check($sformatf("w1_of[%0d]", i), 16'(of1), 16'(model1_ovf(t1[i].a, t1[i].b, t1[i].c)));
`endif
    end
    iv1 = 1'b0;

    // 8-bit boundary vectors, back to back.
    for (int i = 0; i < 6; i++) begin
      iv8 = 1'b1; a8 = t8[i].a; b8 = t8[i].b; c8 = t8[i].c;
      tick();
      check($sformatf("w8_d[%0d]", i),  16'(d8),  16'(t8[i].d));
      check($sformatf("w8_bo[%0d]", i), 16'(bo8), 16'(t8[i].bo));
      check($sformatf("w8_ov[%0d]", i), 16'(ov8), 16'h1);
`ifdef FULL_SUB_OVERFLOW_EN
      check($sformatf("w8_of[%0d]", i), 16'(of8), 16'(t8[i].of));
`endif
    end

    // Idle with undriven operands: results hold, valid drops.
    iv8 = 1'b0; a8 = 'x; b8 = 'x; c8 = 1'bx;
    tick();
    check("hold_ov", 16'(ov8), 16'h0);
    check("hold_d",  16'(d8),  16'h80);
    check("hold_bo", 16'(bo8), 16'h1);
    tick();
    check("hold2_d",  16'(d8),  16'h80);
    check("hold2_bo", 16'(bo8), 16'h1);

    // Reset mid-stream with in_valid high.
    iv8 = 1'b1; a8 = 8'h10; b8 = 8'h20; c8 = 1'b0;
    tick();
    check("pre_d", 16'(d8), 16'hF0);
    rst_n = 1'b0; a8 = 8'h33; b8 = 8'h11;
    tick();
    check("mid_rst_ov", 16'(ov8), 16'h0);
    check("mid_rst_d",  16'(d8),  16'h0);
    check("mid_rst_bo", 16'(bo8), 16'h0);
    rst_n = 1'b1; a8 = 8'h33; b8 = 8'h11; c8 = 1'b1;
    tick();
    check("post_rst_ov", 16'(ov8), 16'h1);
    check("post_rst_d",  16'(d8),  16'h21);
    check("post_rst_bo", 16'(bo8), 16'h0);

    // Random traffic against the arithmetic model.
    exp_v = 1'b1; exp_d = 8'h21; exp_b = 1'b0;
    exp_o = model8_ovf(8'h33, 8'h11, 1'b1);
    for (int n = 0; n < 1000; n++) begin
      iv8 = ($urandom_range(0, 3) != 0);
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      if (n % 97 == 0) begin a8 = 8'h00; b8 = 8'hFF; c8 = 1'b1; end
      if (n % 89 == 0) b8 = a8;
      tick();
      exp_v = iv8;
      if (iv8) begin
        m = model8(a8, b8, c8);
        exp_d = m[7:0]; exp_b = m[8];
        exp_o = model8_ovf(a8, b8, c8);
        if (n % 10 == 0) begin
          r = fs_ref(32'(a8), 32'(b8), c8, 8);
          check("fs_ref", {7'b0, r[32], r[7:0]}, {7'b0, m});
        end
      end
      check("rnd_ov", 16'(ov8), 16'(exp_v));
      check("rnd_d",  16'(d8),  16'(exp_d));
      check("rnd_bo", 16'(bo8), 16'(exp_b));
`ifdef FULL_SUB_OVERFLOW_EN
      check("rnd_of", 16'(of8), 16'(exp_o));
`endif
    end

    // Package reference at WIDTH=1 against the truth table.
    for (int i = 0; i < 8; i++) begin
      r = fs_ref({31'b0, t1[i].a}, {31'b0, t1[i].b}, t1[i].c, 1);
      check($sformatf("fs_ref1[%0d]", i), {14'b0, r[32], r[0]}, {14'b0, t1[i].bo, t1[i].d});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
